// File: rtl/adxl345_pkg.sv
// Shared register map, reset values, FSM state and sample payload for the
// ADXL345 SPI responder.
package adxl345_pkg;

  localparam int unsigned ADDR_W   = 6;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned SAMPLE_W = 16;

  localparam logic [ADDR_W-1:0] ADDR_DEVID       = 6'h00;
  localparam logic [ADDR_W-1:0] ADDR_BW_RATE     = 6'h2C;
  localparam logic [ADDR_W-1:0] ADDR_POWER_CTL   = 6'h2D;
  localparam logic [ADDR_W-1:0] ADDR_INT_ENABLE  = 6'h2E;
  localparam logic [ADDR_W-1:0] ADDR_INT_MAP     = 6'h2F;
  localparam logic [ADDR_W-1:0] ADDR_INT_SOURCE  = 6'h30;
  localparam logic [ADDR_W-1:0] ADDR_DATA_FORMAT = 6'h31;
  localparam logic [ADDR_W-1:0] ADDR_DATAX0      = 6'h32;
  localparam logic [ADDR_W-1:0] ADDR_DATAX1      = 6'h33;
  localparam logic [ADDR_W-1:0] ADDR_DATAY0      = 6'h34;
  localparam logic [ADDR_W-1:0] ADDR_DATAY1      = 6'h35;
  localparam logic [ADDR_W-1:0] ADDR_DATAZ0      = 6'h36;
  localparam logic [ADDR_W-1:0] ADDR_DATAZ1      = 6'h37;

  localparam logic [DATA_W-1:0] RST_BW_RATE     = 8'h0A;
  localparam logic [DATA_W-1:0] RST_POWER_CTL   = 8'h00;
  localparam logic [DATA_W-1:0] RST_INT_ENABLE  = 8'h00;
  localparam logic [DATA_W-1:0] RST_INT_MAP     = 8'h00;
  localparam logic [DATA_W-1:0] RST_DATA_FORMAT = 8'h00;

  localparam int unsigned INT_DATA_READY_BIT    = 7;
  localparam int unsigned POWER_CTL_MEASURE_BIT = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_READ,
    ST_WRITE
  } resp_state_e;

  typedef struct packed {
    logic [SAMPLE_W-1:0] z;
    logic [SAMPLE_W-1:0] y;
    logic [SAMPLE_W-1:0] x;
  } sample_set_t;

  function automatic logic is_data_addr(input logic [ADDR_W-1:0] a);
    return (a >= ADDR_DATAX0) && (a <= ADDR_DATAZ1);
  endfunction

endpackage

// File: rtl/adxl345_spi_responder_if.sv
// 3-wire SPI pad bundle; SDIO is split into pad-in, drive value and enable.
interface adxl345_spi_responder_if;
  logic sclk;
  logic cs_n;
  logic sdio_i;
  logic sdio_o;
  logic sdio_oe;

  modport master (output sclk, output cs_n, output sdio_i, input sdio_o, input sdio_oe);
  modport slave  (input sclk, input cs_n, input sdio_i, output sdio_o, output sdio_oe);
endinterface

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer with an edge-detect flop producing rise/fall pulses.
module spi_edge_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o,
  output logic rise_c_o,
  output logic fall_c_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= STAGES'({sync_q, d_i});
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o      = sync_q[STAGES-1];
  assign rise_c_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_c_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/adxl345_spi_responder.sv
// ADXL345 register-interface emulator on 3-wire SPI (mode 3), fed by an
// external sample source; serves DEVID, control registers and coherent data.
module adxl345_spi_responder
  import adxl345_pkg::*;
#(
  parameter logic [7:0]  DEVID       = 8'hE5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  adxl345_spi_responder_if.slave spi,
  input  logic [SAMPLE_W-1:0]   sample_x,
  input  logic [SAMPLE_W-1:0]   sample_y,
  input  logic [SAMPLE_W-1:0]   sample_z,
  input  logic                  sample_valid,
  output logic                  int1,
  output logic                  int2
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic sdio_lvl, sdio_rise, sdio_fall;

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sclk (
    .clk(clk), .reset(reset), .d_i(spi.sclk),
    .q_o(sclk_lvl), .rise_c_o(sclk_rise), .fall_c_o(sclk_fall)
  );

  // cs_n resets as "selected" so a frame already in progress at reset
  // release never looks like a fresh falling edge.
  spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cs (
    .clk(clk), .reset(reset), .d_i(spi.cs_n),
    .q_o(cs_lvl), .rise_c_o(cs_rise), .fall_c_o(cs_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sdio (
    .clk(clk), .reset(reset), .d_i(spi.sdio_i),
    .q_o(sdio_lvl), .rise_c_o(sdio_rise), .fall_c_o(sdio_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, cs_lvl, sdio_rise, sdio_fall};

  resp_state_e         state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                mb_q, mb_d;
  logic                sdio_o_q, sdio_o_d;
  logic                sdio_oe_q, sdio_oe_d;
  logic                frame_rd_q, frame_rd_d;
  logic                data_ready_q, data_ready_d;
  logic [DATA_W-1:0]   bw_rate_q, bw_rate_d;
  logic [DATA_W-1:0]   power_ctl_q, power_ctl_d;
  logic [DATA_W-1:0]   int_enable_q, int_enable_d;
  logic [DATA_W-1:0]   int_map_q, int_map_d;
  logic [DATA_W-1:0]   data_format_q, data_format_d;
  sample_set_t         live_q, live_d;
  sample_set_t         shadow_q, shadow_d;
  logic                int1_q, int1_d;
  logic                int2_q, int2_d;
  logic [DATA_W-1:0]   rd_data_c;
  logic [DATA_W-1:0]   wr_data_c;
  logic                capture_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      addr_q        <= '0;
      mb_q          <= 1'b0;
      sdio_o_q      <= 1'b1;
      sdio_oe_q     <= 1'b0;
      frame_rd_q    <= 1'b0;
      data_ready_q  <= 1'b0;
      bw_rate_q     <= RST_BW_RATE;
      power_ctl_q   <= RST_POWER_CTL;
      int_enable_q  <= RST_INT_ENABLE;
      int_map_q     <= RST_INT_MAP;
      data_format_q <= RST_DATA_FORMAT;
      live_q        <= '0;
      shadow_q      <= '0;
      int1_q        <= 1'b0;
      int2_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      addr_q        <= addr_d;
      mb_q          <= mb_d;
      sdio_o_q      <= sdio_o_d;
      sdio_oe_q     <= sdio_oe_d;
      frame_rd_q    <= frame_rd_d;
      data_ready_q  <= data_ready_d;
      bw_rate_q     <= bw_rate_d;
      power_ctl_q   <= power_ctl_d;
      int_enable_q  <= int_enable_d;
      int_map_q     <= int_map_d;
      data_format_q <= data_format_d;
      live_q        <= live_d;
      shadow_q      <= shadow_d;
      int1_q        <= int1_d;
      int2_q        <= int2_d;
    end
  end

  // Register read mux; data registers always come from the frame shadow.
  always_comb begin
    rd_data_c = '0;
    case (addr_q)
      ADDR_DEVID:       rd_data_c = DEVID;
      ADDR_BW_RATE:     rd_data_c = bw_rate_q;
      ADDR_POWER_CTL:   rd_data_c = power_ctl_q;
      ADDR_INT_ENABLE:  rd_data_c = int_enable_q;
      ADDR_INT_MAP:     rd_data_c = int_map_q;
      ADDR_INT_SOURCE:  rd_data_c[INT_DATA_READY_BIT] = data_ready_q;
      ADDR_DATA_FORMAT: rd_data_c = data_format_q;
      ADDR_DATAX0:      rd_data_c = shadow_q.x[7:0];
      ADDR_DATAX1:      rd_data_c = shadow_q.x[15:8];
      ADDR_DATAY0:      rd_data_c = shadow_q.y[7:0];
      ADDR_DATAY1:      rd_data_c = shadow_q.y[15:8];
      ADDR_DATAZ0:      rd_data_c = shadow_q.z[7:0];
      ADDR_DATAZ1:      rd_data_c = shadow_q.z[15:8];
      default:          rd_data_c = '0;
    endcase
  end

  assign wr_data_c = {shift_q[6:0], sdio_lvl};
  assign capture_c = sample_valid & power_ctl_q[POWER_CTL_MEASURE_BIT];

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    addr_d        = addr_q;
    mb_d          = mb_q;
    sdio_o_d      = sdio_o_q;
    sdio_oe_d     = sdio_oe_q;
    frame_rd_d    = frame_rd_q;
    data_ready_d  = data_ready_q;
    bw_rate_d     = bw_rate_q;
    power_ctl_d   = power_ctl_q;
    int_enable_d  = int_enable_q;
    int_map_d     = int_map_q;
    data_format_d = data_format_q;
    live_d        = live_q;
    shadow_d      = shadow_q;

    if (cs_rise) begin
      state_d    = ST_IDLE;
      bit_cnt_d  = '0;
      sdio_oe_d  = 1'b0;
      sdio_o_d   = 1'b1;
      frame_rd_d = 1'b0;
      if (frame_rd_q) data_ready_d = 1'b0;
    end else if (cs_fall) begin
      state_d    = ST_ADDR;
      bit_cnt_d  = '0;
      frame_rd_d = 1'b0;
      shadow_d   = live_q;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (sclk_rise) begin
            shift_d   = wr_data_c;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              mb_d    = shift_q[5];
              addr_d  = {shift_q[4:0], sdio_lvl};
              state_d = shift_q[6] ? ST_READ : ST_WRITE;
            end
          end
        end
        ST_READ: begin
          if (sclk_fall) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            sdio_oe_d = 1'b1;
            if (bit_cnt_q == 3'd0) begin
              sdio_o_d = rd_data_c[7];
              shift_d  = {rd_data_c[6:0], 1'b0};
              if (is_data_addr(addr_q)) frame_rd_d = 1'b1;
            end else begin
              sdio_o_d = shift_q[7];
              shift_d  = {shift_q[6:0], 1'b0};
            end
            if (bit_cnt_q == 3'd7 && mb_q) addr_d = addr_q + 6'd1;
          end
        end
        ST_WRITE: begin
          if (sclk_rise) begin
            shift_d   = wr_data_c;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              case (addr_q)
                ADDR_BW_RATE:     bw_rate_d     = wr_data_c;
                ADDR_POWER_CTL:   power_ctl_d   = wr_data_c;
                ADDR_INT_ENABLE:  int_enable_d  = wr_data_c;
                ADDR_INT_MAP:     int_map_d     = wr_data_c;
                ADDR_DATA_FORMAT: data_format_d = wr_data_c;
                default: ;
              endcase
              if (mb_q) addr_d = addr_q + 6'd1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A new sample beats a same-cycle end-of-read clear.
    if (capture_c) begin
      live_d       = '{z: sample_z, y: sample_y, x: sample_x};
      data_ready_d = 1'b1;
    end

    int1_d = data_ready_d & int_enable_d[INT_DATA_READY_BIT] & ~int_map_d[INT_DATA_READY_BIT];
    int2_d = data_ready_d & int_enable_d[INT_DATA_READY_BIT] &  int_map_d[INT_DATA_READY_BIT];
  end

  assign spi.sdio_o  = sdio_o_q;
  assign spi.sdio_oe = sdio_oe_q;
  assign int1        = int1_q;
  assign int2        = int2_q;

endmodule

// File: tb/tb_adxl345_spi_responder.sv
// Directed bench for the ADXL345 SPI responder: register access, sample
// coherence, interrupts, aborted write and mid-frame reset.
module tb_adxl345_spi_responder;

  localparam int HALF = 80;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sx, sy, sz;
  logic        sv;
  logic        int1, int2;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  adxl345_spi_responder_if spi ();

  adxl345_spi_responder #(.DEVID(8'hE5), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .spi(spi),
    .sample_x(sx), .sample_y(sy), .sample_z(sz), .sample_valid(sv),
    .int1(int1), .int2(int2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    spi.sclk = 1'b0; spi.sdio_i = b; #HALF;
    spi.sclk = 1'b1; #HALF;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    spi.sdio_i = 1'b1;
  endtask

  task automatic recv_byte(output logic [7:0] b, output logic oe_all);
    oe_all = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      spi.sclk = 1'b0; #HALF;
      b[i] = spi.sdio_o;
      oe_all &= spi.sdio_oe;
      spi.sclk = 1'b1; #HALF;
    end
  endtask

  task automatic end_frame();
    spi.cs_n = 1'b1; #(2*HALF);
  endtask

  task automatic write_reg(input logic [5:0] a, input logic [7:0] d);
    spi.cs_n = 1'b0; #HALF;
    send_byte({2'b00, a});
    send_byte(d);
    end_frame();
  endtask

  task automatic read_reg(input string tag, input logic [5:0] a, input logic [7:0] exp);
    logic [7:0] d;
    logic       oe;
    spi.cs_n = 1'b0; #HALF;
    send_byte({2'b10, a});
    recv_byte(d, oe);
    end_frame();
    check(tag, 32'(d), 32'(exp));
  endtask

  initial begin
    logic [7:0] d;
    logic       oe;
    logic [7:0] exp_bytes [6];
    exp_bytes = '{8'h23, 8'h01, 8'h80, 8'hFF, 8'h00, 8'h01};

    reset = 1'b1; spi.cs_n = 1'b1; spi.sclk = 1'b1; spi.sdio_i = 1'b1;
    sv = 1'b0; sx = '0; sy = '0; sz = '0;
    #30;
    check("rst_sdio_o", 32'(spi.sdio_o), 32'd1);
    check("rst_sdio_oe", 32'(spi.sdio_oe), 32'd0);
    check("rst_int1", 32'(int1), 32'd0);
    check("rst_int2", 32'(int2), 32'd0);
    reset = 1'b0; #(2*HALF);

    // DEVID read with output-enable phase checks
    spi.cs_n = 1'b0; #HALF;
    send_byte(8'h80);
    check("oe_addr_phase", 32'(spi.sdio_oe), 32'd0);
    recv_byte(d, oe);
    check("devid", 32'(d), 32'hE5);
    check("oe_data_phase", 32'(oe), 32'd1);
    end_frame();
    check("oe_after_frame", 32'(spi.sdio_oe), 32'd0);

    write_reg(6'h2D, 8'h08);
    read_reg("power_ctl_rw", 6'h2D, 8'h08);
    write_reg(6'h00, 8'h55);
    read_reg("devid_ro", 6'h00, 8'hE5);
    read_reg("bw_rate_default", 6'h2C, 8'h0A);

    // Coherent 6-byte MB read with a sample arriving mid-frame
    sx = 16'h0123; sy = 16'hFF80; sz = 16'h0100;
    sv = 1'b1; #10; sv = 1'b0; #20;
    read_reg("int_source_dr", 6'h30, 8'h80);
    spi.cs_n = 1'b0; #HALF;
    send_byte(8'hF2);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        sx = 16'h7777; sy = 16'h6666; sz = 16'h5555;
        sv = 1'b1; #10; sv = 1'b0;
      end
      recv_byte(d, oe);
      check($sformatf("mb_byte%0d", i), 32'(d), 32'(exp_bytes[i]));
    end
    end_frame();
    read_reg("next_snapshot", 6'h32, 8'h77);

    // DATA_READY routed to int1
    write_reg(6'h2E, 8'h80);
    check("int1_idle", 32'(int1), 32'd0);
    sv = 1'b1; #10; sv = 1'b0;
    check("int1_set", 32'(int1), 32'd1);
    check("int2_clr", 32'(int2), 32'd0);
    read_reg("data_read", 6'h33, 8'h77);
    check("int1_cleared", 32'(int1), 32'd0);

    // DATA_READY routed to int2
    write_reg(6'h2F, 8'h80);
    sv = 1'b1; #10; sv = 1'b0;
    check("int2_set", 32'(int2), 32'd1);
    check("int1_off", 32'(int1), 32'd0);

    // Write aborted after 5 data bits
    spi.cs_n = 1'b0; #HALF;
    send_byte(8'h2C);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    end_frame();
    check("abort_oe", 32'(spi.sdio_oe), 32'd0);
    read_reg("abort_bw_rate", 6'h2C, 8'h0A);
    read_reg("after_abort", 6'h2F, 8'h80);

    // Reset during the read data phase
    spi.cs_n = 1'b0; #HALF;
    send_byte(8'hAD);
    for (int i = 0; i < 3; i++) begin
      spi.sclk = 1'b0; #HALF; spi.sclk = 1'b1; #HALF;
    end
    check("oe_before_reset", 32'(spi.sdio_oe), 32'd1);
    reset = 1'b1; #30;
    check("reset_oe", 32'(spi.sdio_oe), 32'd0);
    check("reset_sdio_o", 32'(spi.sdio_o), 32'd1);
    check("reset_int2", 32'(int2), 32'd0);
    reset = 1'b0; #20;
    for (int i = 0; i < 5; i++) begin
      spi.sclk = 1'b0; #HALF;
      check($sformatf("post_reset_oe%0d", i), 32'(spi.sdio_oe), 32'd0);
      spi.sclk = 1'b1; #HALF;
    end
    end_frame();
    read_reg("reset_power_ctl", 6'h2D, 8'h00);
    read_reg("reset_int_map", 6'h2F, 8'h00);
    read_reg("reset_bw_rate", 6'h2C, 8'h0A);
    read_reg("reset_int_source", 6'h30, 8'h00);
    read_reg("devid_after_reset", 6'h00, 8'hE5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
